// File: rtl/program_loader.sv
// program_loader: byte-stream boot loader for the MC14500B program ROM.
//
// Frame format (bytes, as received): SYNC, len, {lo, hi} x N, checksum.
//   len = 0 means 256 words. checksum = XOR of len and every data byte.
//   Each word is written to ROM as {hi[CODE-1:0], lo}, at addresses 0..N-1.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   rx_data       received byte
//   rx_valid      rx_data valid
//   rx_ready      loader accepts rx_data this cycle (low only on the write cycle)
//   program_write one-cycle ROM write strobe
//   program_cmd   command word to write
//   prog_addr     ROM write address
//   load_active   frame in progress
//   core_rst      reset request to the core; released only by a good frame
//   load_done     last frame loaded with a good checksum
//   load_err      last frame had a checksum mismatch
module program_loader #(
  parameter int unsigned ADDR = 8,
  parameter int unsigned CODE = 4,
  parameter int unsigned WORD = ADDR + CODE,
  parameter logic [7:0]  SYNC = 8'hA5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic            rx_ready,
  output logic            program_write,
  output logic [WORD-1:0] program_cmd,
  output logic [ADDR-1:0] prog_addr,
  output logic            load_active,
  output logic            core_rst,
  output logic            load_done,
  output logic            load_err
);

  typedef enum logic [2:0] {StIdle, StLen, StLo, StHi, StWr, StCsum} state_e;

  state_e          state_q;
  logic [ADDR:0]   idx_q;
  logic [ADDR:0]   len_q;
  logic [7:0]      csum_q;
  logic [ADDR-1:0] lo_q;
  logic            accept;
  logic [ADDR:0]   idx_next;

  assign accept   = rx_valid && rx_ready;
  assign idx_next = idx_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      rx_ready      <= 1'b1;
      program_write <= 1'b0;
      program_cmd   <= '0;
      prog_addr     <= '0;
      load_active   <= 1'b0;
      core_rst      <= 1'b1;
      load_done     <= 1'b0;
      load_err      <= 1'b0;
      idx_q         <= '0;
      len_q         <= '0;
      csum_q        <= '0;
      lo_q          <= '0;
    end else begin
      program_write <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept && rx_data == SYNC) begin
            state_q     <= StLen;
            load_active <= 1'b1;
            core_rst    <= 1'b1;
            load_done   <= 1'b0;
            load_err    <= 1'b0;
            csum_q      <= '0;
          end
        end
        StLen: begin
          if (accept) begin
            // ADDR is 8, so a zero length byte becomes 9'h100 (256 words).
            len_q   <= {rx_data == 8'h00, rx_data};
            csum_q  <= csum_q ^ rx_data;
            idx_q   <= '0;
            state_q <= StLo;
          end
        end
        StLo: begin
          if (accept) begin
            lo_q    <= rx_data;
            csum_q  <= csum_q ^ rx_data;
            state_q <= StHi;
          end
        end
        StHi: begin
          if (accept) begin
            csum_q        <= csum_q ^ rx_data;
            program_cmd   <= {rx_data[CODE-1:0], lo_q};
            prog_addr     <= idx_q[ADDR-1:0];
            program_write <= 1'b1;
            rx_ready      <= 1'b0;
            state_q       <= StWr;
          end
        end
        StWr: begin
          idx_q    <= idx_next;
          rx_ready <= 1'b1;
          state_q  <= (idx_next == len_q) ? StCsum : StLo;
        end
        StCsum: begin
          if (accept) begin
            if (rx_data == csum_q) begin
              load_done <= 1'b1;
              core_rst  <= 1'b0;
            end else begin
              load_err  <= 1'b1;
            end
            load_active <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q     <= StIdle;
          rx_ready    <= 1'b1;
          load_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        program_write;
  logic [11:0] program_cmd;
  logic [7:0]  prog_addr;
  logic        load_active;
  logic        core_rst;
  logic        load_done;
  logic        load_err;

  always #5 clk = ~clk;

  program_loader dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .program_write(program_write),
    .program_cmd  (program_cmd),
    .prog_addr    (prog_addr),
    .load_active  (load_active),
    .core_rst     (core_rst),
    .load_done    (load_done),
    .load_err     (load_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [11:0] cmd;
  } wr_t;

  wr_t        got_q[$];
  wr_t        exp_q[$];
  logic [7:0] stim_q[$];
  bit         m_done, m_err, m_crst;

  typedef struct {
    logic [95:0] b;
    int          n;
    bit          done;
    bit          err;
    bit          crst;
    int          nwr;
    logic [11:0] c0;
    logic [11:0] c1;
  } vec_t;

  vec_t vt[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: ready must be low exactly on write cycles; writes >= 3 cycles apart.
  int cyc = 0;
  int last_wr = -100;
  always @(negedge clk) begin
    check("ready_vs_write", {31'b0, rx_ready}, {31'b0, ~program_write});
    if (program_write === 1'b1) begin
      got_q.push_back('{prog_addr, program_cmd});
      check("write_spacing_ok", {31'b0, (cyc - last_wr) >= 3}, 32'd1);
      last_wr = cyc;
    end
    cyc++;
  end

  // Reference: parse the byte list frame by frame from the protocol rules.
  task automatic model_run();
    int i = 0;
    int n;
    logic [7:0] x, lo, hi;
    while (i < stim_q.size()) begin
      if (stim_q[i] != 8'hA5) begin
        i++;
        continue;
      end
      m_done = 0; m_err = 0; m_crst = 1;
      x = stim_q[i+1];
      n = (stim_q[i+1] == 8'h00) ? 256 : int'(stim_q[i+1]);
      for (int k = 0; k < n; k++) begin
        lo = stim_q[i+2+2*k];
        hi = stim_q[i+3+2*k];
        exp_q.push_back('{8'(k), {hi[3:0], lo}});
        x = x ^ lo ^ hi;
      end
      if (stim_q[i+2+2*n] == x) begin
        m_done = 1; m_crst = 0;
      end else begin
        m_err = 1;
      end
      i += 3 + 2 * n;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = rx_ready;
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: byte %0h not accepted, required acceptance in 50 cycles", b);
    end
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_stim(input int maxgap);
    foreach (stim_q[i]) send_byte(stim_q[i], $urandom_range(0, maxgap));
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_done = 0; m_err = 0; m_crst = 1;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      check({tag, "_addr"}, {24'b0, got_q[k].addr}, {24'b0, exp_q[k].addr});
      check({tag, "_cmd"}, {20'b0, got_q[k].cmd}, {20'b0, exp_q[k].cmd});
    end
    check({tag, "_done"}, {31'b0, load_done}, {31'b0, m_done});
    check({tag, "_err"}, {31'b0, load_err}, {31'b0, m_err});
    check({tag, "_core_rst"}, {31'b0, core_rst}, {31'b0, m_crst});
    check({tag, "_active"}, {31'b0, load_active}, 32'd0);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
    $fatal(1);
  end

  initial begin
    logic [95:0] bv;
    logic [7:0]  x;
    int          len;

    vt[0] = '{{8'hA5, 8'h02, 8'h10, 8'h03, 8'h20, 8'h07, 8'h36, 40'h0}, 7,
              1, 0, 0, 2, 12'h310, 12'h720};
    vt[1] = '{{8'hA5, 8'h02, 8'h10, 8'h03, 8'h20, 8'h07, 8'h00, 40'h0}, 7,
              0, 1, 1, 2, 12'h310, 12'h720};
    vt[2] = '{{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'h10, 8'h03, 8'h20, 8'h07, 8'h36, 16'h0}, 10,
              1, 0, 0, 2, 12'h310, 12'h720};
    vt[3] = '{{8'hA5, 8'h01, 8'hAB, 8'hF5, 8'h5F, 56'h0}, 5,
              1, 0, 0, 1, 12'h5AB, 12'h000};
    vt[4] = '{{8'hA5, 8'h01, 8'hA5, 8'hA5, 8'h01, 56'h0}, 5,
              1, 0, 0, 1, 12'h5A5, 12'h000};

    do_reset();
    check("rst_rx_ready", {31'b0, rx_ready}, 32'd1);
    check("rst_write", {31'b0, program_write}, 32'd0);
    check("rst_cmd", {20'b0, program_cmd}, 32'd0);
    check("rst_addr", {24'b0, prog_addr}, 32'd0);
    check("rst_active", {31'b0, load_active}, 32'd0);
    check("rst_core_rst", {31'b0, core_rst}, 32'd1);
    check("rst_done", {31'b0, load_done}, 32'd0);
    check("rst_err", {31'b0, load_err}, 32'd0);

    // Table-driven frames, with random rx_valid gaps.
    for (int v = 0; v < 5; v++) begin
      bv = vt[v].b;
      stim_q.delete();
      got_q.delete();
      for (int k = 0; k < vt[v].n; k++) stim_q.push_back(bv[95-8*k -: 8]);
      send_stim(3);
      check($sformatf("tab%0d_nwr", v), got_q.size(), vt[v].nwr);
      if (got_q.size() >= 1) begin
        check($sformatf("tab%0d_addr0", v), {24'b0, got_q[0].addr}, 32'd0);
        check($sformatf("tab%0d_cmd0", v), {20'b0, got_q[0].cmd}, {20'b0, vt[v].c0});
      end
      if (got_q.size() >= 2) begin
        check($sformatf("tab%0d_addr1", v), {24'b0, got_q[1].addr}, 32'd1);
        check($sformatf("tab%0d_cmd1", v), {20'b0, got_q[1].cmd}, {20'b0, vt[v].c1});
      end
      check($sformatf("tab%0d_done", v), {31'b0, load_done}, {31'b0, vt[v].done});
      check($sformatf("tab%0d_err", v), {31'b0, load_err}, {31'b0, vt[v].err});
      check($sformatf("tab%0d_core_rst", v), {31'b0, core_rst}, {31'b0, vt[v].crst});
      check($sformatf("tab%0d_active", v), {31'b0, load_active}, 32'd0);
    end

    // rst after the first LO byte: nothing written, core held.
    got_q.delete();
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h10, 0);
    do_reset();
    check("midrst_nowrite", got_q.size(), 32'd0);
    check("midrst_active", {31'b0, load_active}, 32'd0);
    check("midrst_core_rst", {31'b0, core_rst}, 32'd1);
    check("midrst_ready", {31'b0, rx_ready}, 32'd1);
    stim_q = '{8'hA5, 8'h02, 8'h10, 8'h03, 8'h20, 8'h07, 8'h36};
    model_run();
    send_stim(0);
    compare_model("after_rst");

    // Reload after done: SYNC re-asserts core_rst and clears done.
    stim_q = '{8'hA5, 8'h01, 8'hAB, 8'hF5, 8'h5F};
    model_run();
    send_byte(8'hA5, 0);
    check("reload_core_rst", {31'b0, core_rst}, 32'd1);
    check("reload_done_clr", {31'b0, load_done}, 32'd0);
    check("reload_active", {31'b0, load_active}, 32'd1);
    void'(stim_q.pop_front());
    send_stim(1);
    compare_model("reload");

    // Length 0 loads 256 words at addresses 0..255.
    stim_q = '{8'hA5, 8'h00};
    for (int k = 0; k < 512; k++) stim_q.push_back(8'($urandom));
    x = 8'h00;
    for (int k = 1; k < 514; k++) x = x ^ stim_q[k];
    stim_q.push_back(x);
    model_run();
    send_stim(0);
    compare_model("len256");

    // Random frames: leading garbage, random length/data, good or bad checksum.
    for (int f = 0; f < 20; f++) begin
      stim_q.delete();
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        x = 8'($urandom);
        stim_q.push_back((x == 8'hA5) ? 8'h00 : x);
      end
      len = $urandom_range(1, 6);
      stim_q.push_back(8'hA5);
      stim_q.push_back(8'(len));
      x = 8'(len);
      for (int k = 0; k < 2 * len; k++) begin
        stim_q.push_back(8'($urandom));
        x = x ^ stim_q[stim_q.size()-1];
      end
      stim_q.push_back(($urandom_range(0, 3) == 0) ? x + 8'h01 : x);
      model_run();
      send_stim(3);
      compare_model($sformatf("rand%0d", f));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
